// File: rtl/axis_pkg.sv
// Shared AXI-Stream defaults and helpers, used by the stream mux and the stream FIFO.
package axis_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 8;
    localparam int unsigned AXIS_FIFO_DEPTH = 4;

    // Pointer width for a FIFO of the given depth: index bits plus one wrap bit.
    function automatic int unsigned axis_ptr_width(input int unsigned depth);
        return $unsigned($clog2(depth)) + 32'd1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Storage array for axi_stream_fifo: synchronous write, asynchronous read, no reset.
module axis_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_stream_fifo.sv
// First-word-fall-through AXI-Stream FIFO with registered ready/valid flags.
// Define AXIS_FIFO_LEVEL_EN to add the registered occupancy output 'level'.
module axi_stream_fifo
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int unsigned DEPTH      = AXIS_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready
`ifdef AXIS_FIFO_LEVEL_EN
    ,
    output logic [axis_ptr_width(DEPTH)-1:0] level
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = axis_ptr_width(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic          wr_en;
    logic          rd_en;
    logic          empty_nxt;
    logic          full_nxt;

    // Flags are computed from the post-edge pointers so they can be registered.
    always_comb begin
        wr_en      = s_tvalid && s_tready;
        rd_en      = m_tvalid && m_tready;
        wr_ptr_nxt = wr_ptr + PW'(wr_en);
        rd_ptr_nxt = rd_ptr + PW'(rd_en);
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            s_tready <= 1'b0;
            m_tvalid <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            s_tready <= !full_nxt;
            m_tvalid <= !empty_nxt;
        end
    end

`ifdef AXIS_FIFO_LEVEL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            level <= wr_ptr_nxt - rd_ptr_nxt;
        end
    end
`endif

    axis_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (s_tdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (m_tdata)
    );

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Scoreboard bench for axi_stream_fifo (DEPTH = 4, DATA_WIDTH = 8).
module tb_axi_stream_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
`ifdef AXIS_FIFO_LEVEL_EN
    logic [PW-1:0] level;
`endif

    axi_stream_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
`ifdef AXIS_FIFO_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_rx     = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] mon_exp;
    logic [DW-1:0] fill_v [4];
    bit            soak_run;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Offer one beat, hold it until accepted, record it as expected output.
    task automatic send(input logic [DW-1:0] d);
        int t;
        @(posedge clk); #1;
        s_tdata  = d;
        s_tvalid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            t++;
            if (t > 200) begin
                check("send_timeout", 32'(s_tready), 32'd1);
                s_tvalid = 1'b0;
                return;
            end
        end
        sb.push_back(d);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (m_tvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(m_tvalid), 32'd0);
    endtask

    task automatic wait_rx(input int target);
        int t;
        t = 0;
        while (n_rx < target && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("soak_count", 32'(n_rx), 32'(target));
    endtask

    // Monitor: every read handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL mon_underflow: got beat %0h, expected none", m_tdata);
            end else begin
                mon_exp = sb.pop_front();
                check("mon_data", 32'(m_tdata), 32'(mon_exp));
                n_rx++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_v[0] = 8'h11; fill_v[1] = 8'h22; fill_v[2] = 8'h33; fill_v[3] = 8'h44;
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        soak_run = 1'b0;

        // Reset state
        #1;
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_s_tready", 32'(s_tready), 32'd1);

        // Fill to full with the sink stalled
        for (int i = 0; i < 4; i++) send(fill_v[i]);
        check("full_s_tready", 32'(s_tready), 32'd0);
        check("full_m_tvalid", 32'(m_tvalid), 32'd1);
        check("full_head", 32'(m_tdata), 32'h11);
`ifdef AXIS_FIFO_LEVEL_EN
        check("full_level", 32'(level), 32'd4);
`endif

        // Fifth beat waits upstream, then drain shows 4 consecutive beats
        fork
            send(8'h55);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("full_hold_tready", 32'(s_tready), 32'd0);
                end
                @(posedge clk); #1;
                m_tready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("drain_valid", 32'(m_tvalid), 32'd1);
                    check("drain_data", 32'(m_tdata), 32'(fill_v[i]));
                end
            end
        join
        wait_empty("drain_empty");
        check("drain_rx", 32'(n_rx), 32'd5);

        // Simultaneous read/write at level 2 across pointer wrap
        m_tready = 1'b0;
        send(8'hA0);
        send(8'hA1);
        for (int i = 0; i < 10; i++) begin
            s_tdata  = DW'(8'hB0 + i);
            s_tvalid = 1'b1;
            m_tready = 1'b1;
            @(negedge clk);
            check("rw_flags", {30'd0, s_tready, m_tvalid}, 32'd3);
            if (s_tready) sb.push_back(s_tdata);
            @(posedge clk); #1;
`ifdef AXIS_FIFO_LEVEL_EN
            check("rw_level", 32'(level), 32'd2);
`endif
        end
        s_tvalid = 1'b0;
        wait_empty("rw_empty");

        // Backpressure stall holds data
        m_tready = 1'b0;
        send(8'h5A);
        send(8'h6B);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(m_tvalid), 32'd1);
            check("stall_data", 32'(m_tdata), 32'h5A);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_empty("stall_empty");

        // Random soak
        begin
            int target;
            target   = n_rx + 1000;
            soak_run = 1'b1;
            fork
                begin
                    for (int i = 0; i < 1000; i++) begin
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        send(DW'($urandom));
                    end
                    wait_rx(target);
                    soak_run = 1'b0;
                end
                begin
                    while (soak_run) begin
                        @(posedge clk); #1;
                        m_tready = 1'($urandom_range(0, 1));
                    end
                end
            join
            check("soak_sb_empty", 32'(sb.size()), 32'd0);
        end

        // Reset mid-stream with two beats stored
        m_tready = 1'b0;
        send(8'hC1);
        send(8'hC2);
        @(negedge clk);
        check("pre_rst_valid", 32'(m_tvalid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_s_tready", 32'(s_tready), 32'd0);
`ifdef AXIS_FIFO_LEVEL_EN
        check("mid_rst_level", 32'(level), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_s_tready", 32'(s_tready), 32'd1);
        check("post_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        m_tready = 1'b1;
        send(8'hD1);
        wait_empty("post_rst_empty");
        check("post_rst_sb", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_stream_fifo.md
AXI_STREAM_FIFO -- requirements
Module: axi_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the tdata width in bits on both ports.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of storage entries; legal values are powers of two from 2 to 64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_tdata, input, DATA_WIDTH bits: upstream data, driven by the stream mux output.
REQ-006 SHALL have port s_tvalid, input, 1 bit: upstream valid.
REQ-007 SHALL have port s_tready, output, 1 bit: the FIFO can accept a beat.
REQ-008 SHALL have port m_tdata, output, DATA_WIDTH bits: downstream data.
REQ-009 SHALL have port m_tvalid, output, 1 bit: downstream valid.
REQ-010 SHALL have port m_tready, input, 1 bit: downstream ready.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1 bits, present only under AXIS_FIFO_LEVEL_EN: the current occupancy.

Function
REQ-012 SHALL accept a beat (write) in a cycle where s_tvalid and s_tready are both 1 at the rising clk edge.
REQ-013 SHALL deliver a beat (read) in a cycle where m_tvalid and m_tready are both 1 at the rising clk edge.
REQ-014 SHALL drive s_tready = 1 exactly when the FIFO is not full; the value is a registered flag and does not combinationally depend on m_tready.
REQ-015 SHALL drive m_tvalid = 1 exactly when the FIFO is not empty; the value is a registered flag and does not combinationally depend on s_tvalid.
REQ-016 SHALL be first-word-fall-through: m_tdata always shows the oldest stored entry, and m_tdata is don't-care while m_tvalid is 0.
REQ-017 SHALL have latency of exactly 1 clock from an accepted write into an empty FIFO to m_tvalid = 1; there is no combinational bypass path.
REQ-018 SHALL hold m_tdata and m_tvalid stable while m_tvalid = 1 and m_tready = 0 (AXI-Stream no-retraction rule).
REQ-019 SHALL leave occupancy unchanged on a simultaneous read and write, with both pointers advancing.
REQ-020 SHALL, when full, perform no write in that cycle even if m_tready = 1 (s_tready was 0); s_tready rises on the following cycle.
REQ-021 SHALL, when empty, perform no read; m_tready is ignored.
REQ-022 SHALL use read and write pointers of $clog2(DEPTH)+1 bits that wrap modulo 2*DEPTH; the FIFO is empty when the pointers are equal and full when the MSBs differ and the remaining bits are equal.
REQ-023 SHALL never overwrite unread data and never deliver a beat twice, including across pointer wrap-around.

Reset
REQ-024 SHALL, while rst_n = 0, asynchronously clear both pointers and force s_tready = 0, m_tvalid = 0 and level = 0.
REQ-025 SHALL drive s_tready = 1 on the first rising clk edge after rst_n deasserts.
REQ-026 SHALL discard all stored beats on reset mid-operation; the storage array itself needs no reset.

Configuration
REQ-027 SHALL, with macro AXIS_FIFO_LEVEL_EN defined, provide the level port, registered and updated in the same edge as the pointers, with a range of 0 to DEPTH.
REQ-028 SHALL, with AXIS_FIFO_LEVEL_EN undefined, have no level port and no level logic; all other behaviour is identical.

Structure
REQ-029 SHALL take the defaults for DATA_WIDTH and DEPTH, plus a pointer-width helper constant, from the shared package axis_pkg, which the stream mux also uses.
REQ-030 SHALL place the storage array in one sub-module, axis_fifo_ram (synchronous write, asynchronous read); the pointer and flag logic stays in the top module.

Verification
REQ-031 SHALL cover reset: assert rst_n = 0 mid-stream with 2 beats stored -> m_tvalid = 0 and level = 0 immediately; s_tready = 1 one edge after release.
REQ-032 SHALL cover fill to full: DEPTH = 4, write 0x11, 0x22, 0x33, 0x44 with m_tready = 0 -> s_tready = 0 after the 4th accept, level = 4, and a 5th beat 0x55 is held upstream, not lost.
REQ-033 SHALL cover drain: from full, set m_tready = 1 -> outputs 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, then m_tvalid = 0.
REQ-034 SHALL cover simultaneous read/write at level 2 -> level stays 2 over 10 cycles, and data order is preserved across pointer wrap.
REQ-035 SHALL cover backpressure stall: m_tvalid = 1 with m_tready = 0 for 5 cycles -> m_tdata is unchanged throughout.
REQ-036 SHALL cover a random soak: random s_tvalid and m_tready over 1000 beats fed from the stream mux -> the output sequence equals the input sequence, with no overflow or underflow.
